multicycle_sequencer: RTL and testbench

Multi-cycle control sequencer for the 16-bit RISC datapath. It replaces single-cycle opcode decode with an FSM that steps each instruction through FETCH/DECODE/EXEC/MEM/WB. It drives the PC, IR, register-file, ALU and memory enables one state at a time, and handles memory wait states. It sits between the instruction register's opcode field and the datapath control inputs, and also keeps a retired-instruction counter.

---
 rtl/multicycle_sequencer_if.sv | 56 +++++
 rtl/multicycle_sequencer.sv | 246 ++++++++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_sequencer_if.sv
// -----------------------------------------------------------------------------
// multicycle_sequencer_if
//
// Connects the multi-cycle control sequencer to the 16-bit RISC datapath.
// It carries the opcode, status and handshake inputs toward the sequencer and
// the per-state control enables back to the datapath.
//
//   master : the sequencer (drives the control enables)
//   slave  : the datapath / memory side (drives opcode, flags, mem_ready)
//
// CNT_W must match the CNT_W of the multicycle_sequencer that uses this bus.
// -----------------------------------------------------------------------------
interface multicycle_sequencer_if #(
    parameter int CNT_W = 16
);

    // datapath / memory -> sequencer
    logic [3:0]       opcode;       // IR[15:12]
    logic             zero;         // ALU zero flag
    logic             mem_ready;    // memory access completes this cycle
    logic             halt_req;     // stop before the next fetch

    // sequencer -> datapath
    logic             pc_write;
    logic [1:0]       pc_src;       // 00 PC+2, 01 branch target, 10 jump target
    logic             ir_write;
    logic             imem_read;
    logic             mem_read_en;
    logic             mem_write_en;
    logic             alu_src;      // 0 register, 1 immediate
    logic [2:0]       alu_op;
    logic             reg_dst;      // 1 rd, 0 rt
    logic             mem_to_reg;
    logic             reg_write_en;
    logic             illegal_op;
    logic             halted;
    logic [2:0]       state_dbg;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  opcode, zero, mem_ready, halt_req,
        output pc_write, pc_src, ir_write, imem_read,
               mem_read_en, mem_write_en, alu_src, alu_op,
               reg_dst, mem_to_reg, reg_write_en,
               illegal_op, halted, state_dbg, instr_count
    );

    modport slave (
        output opcode, zero, mem_ready, halt_req,
        input  pc_write, pc_src, ir_write, imem_read,
               mem_read_en, mem_write_en, alu_src, alu_op,
               reg_dst, mem_to_reg, reg_write_en,
               illegal_op, halted, state_dbg, instr_count
    );

endinterface

// File: rtl/multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// multicycle_sequencer
//
// Multi-cycle control FSM for the 16-bit RISC datapath. Each instruction walks
// FETCH -> DECODE -> EXEC -> MEM -> WB (skipping states it does not need) and
// the datapath enables are driven one state at a time. A retired-instruction
// counter increments on every edge that completes an instruction.
//
// Compile-time option:
//   MEM_WAIT_EN  defined   : FETCH and MEM stall until mem_ready = 1.
//                undefined : mem_ready is ignored; FETCH and MEM take exactly
//                            one cycle.
//
// Reset is synchronous and active-low. While rst_n = 0 every control output
// is held at 0 combinationally.
// -----------------------------------------------------------------------------
module multicycle_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_sequencer_if.master bus
);

    // State encoding is visible on state_dbg, so values are fixed.
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    // Instruction classes; the FSM only cares which path an opcode takes.
    typedef enum logic [2:0] {
        K_LW,
        K_SW,
        K_ALU,
        K_BEQ,
        K_BNE,
        K_JMP,
        K_ILL
    } kind_e;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    // Everything that is gated to zero during reset travels in one bundle.
    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       imem_read;
        logic       mem_read_en;
        logic       mem_write_en;
        logic       alu_src;
        logic [2:0] alu_op;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write_en;
        logic       illegal_op;
        logic       halted;
    } ctl_t;

    function automatic kind_e decode_op(input logic [3:0] op);
        kind_e k;
        case (op)
            4'b0000: k = K_LW;
            4'b0001: k = K_SW;
            4'b0010, 4'b0011, 4'b0100, 4'b0101,
            4'b0110, 4'b0111, 4'b1000, 4'b1001: k = K_ALU;
            4'b1011: k = K_BEQ;
            4'b1100: k = K_BNE;
            4'b1101: k = K_JMP;
            default: k = K_ILL;
        endcase
        return k;
    endfunction

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] count_q;
    logic             retire;
    logic             rdy;
    kind_e            kind;
    logic [3:0]       op_minus2;
    logic [2:0]       alu_map;
    ctl_t             ctl;
    ctl_t             ctl_out;

`ifdef MEM_WAIT_EN
    assign rdy = bus.mem_ready;
`else
    // Memory is assumed single-cycle; the handshake input is deliberately
    // left unconnected to the FSM.
    logic mem_ready_unused;
    assign mem_ready_unused = bus.mem_ready;
    assign rdy              = 1'b1;
`endif

    assign kind      = decode_op(bus.opcode);
    // ALU opcodes 0010..1001 map onto alu_op 000..111 in order.
    assign op_minus2 = bus.opcode - 4'd2;
    assign alu_map   = op_minus2[2:0];

    // State register and retired-instruction counter (synchronous reset).
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (!rst_n) begin
            state_q <= S_FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    // Next-state, retire and per-state control decode.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d = state_q;
        retire  = 1'b0;
        ctl     = '0;

        case (state_q)
            S_FETCH: begin
                if (bus.halt_req) begin
                    ctl.halted = 1'b1;
                end else begin
                    ctl.imem_read = 1'b1;
                    if (rdy) begin
                        ctl.ir_write = 1'b1;
                        ctl.pc_write = 1'b1;
                        ctl.pc_src   = PC_SEQ;
                        state_d      = S_DECODE;
                    end
                end
            end

            S_DECODE: begin
                case (kind)
                    K_JMP: begin
                        ctl.pc_write = 1'b1;
                        ctl.pc_src   = PC_JUMP;
                        retire       = 1'b1;
                        state_d      = S_FETCH;
                    end
                    K_ILL: begin
                        ctl.illegal_op = 1'b1;
                        state_d        = S_FETCH;
                    end
                    default: state_d = S_EXEC;
                endcase
            end

            S_EXEC: begin
                case (kind)
                    K_LW, K_SW: begin
                        ctl.alu_src = 1'b1;
                        ctl.alu_op  = ALU_ADD;
                        state_d     = S_MEM;
                    end
                    K_ALU: begin
                        ctl.reg_dst = 1'b1;
                        ctl.alu_op  = alu_map;
                        state_d     = S_WB;
                    end
                    K_BEQ, K_BNE: begin
                        ctl.alu_op   = ALU_SUB;
                        ctl.pc_src   = PC_BRANCH;
                        ctl.pc_write = (kind == K_BEQ) ? bus.zero : ~bus.zero;
                        retire       = 1'b1;
                        state_d      = S_FETCH;
                    end
                    // Opcode changed under the FSM; drop back to fetch.
                    default: state_d = S_FETCH;
                endcase
            end

            S_MEM: begin
                // Address stays computed as base + immediate for the access.
                ctl.alu_src = 1'b1;
                ctl.alu_op  = ALU_ADD;
                case (kind)
                    K_LW: begin
                        ctl.mem_read_en = 1'b1;
                        if (rdy) begin
                            state_d = S_WB;
                        end
                    end
                    K_SW: begin
                        ctl.mem_write_en = 1'b1;
                        if (rdy) begin
                            retire  = 1'b1;
                            state_d = S_FETCH;
                        end
                    end
                    default: state_d = S_FETCH;
                endcase
            end

            S_WB: begin
                ctl.reg_write_en = 1'b1;
                retire           = 1'b1;
                state_d          = S_FETCH;
                if (kind == K_LW) begin
                    ctl.mem_to_reg = 1'b1;
                    ctl.reg_dst    = 1'b0;
                end else if (kind == K_ALU) begin
                    ctl.reg_dst = 1'b1;
                    ctl.alu_op  = alu_map;
                end
            end

            default: state_d = S_FETCH;
        endcase
    end

    // Control outputs are forced low for as long as reset is held.
    assign ctl_out = rst_n ? ctl : '0;

    assign bus.pc_write     = ctl_out.pc_write;
    assign bus.pc_src       = ctl_out.pc_src;
    assign bus.ir_write     = ctl_out.ir_write;
    assign bus.imem_read    = ctl_out.imem_read;
    assign bus.mem_read_en  = ctl_out.mem_read_en;
    assign bus.mem_write_en = ctl_out.mem_write_en;
    assign bus.alu_src      = ctl_out.alu_src;
    assign bus.alu_op       = ctl_out.alu_op;
    assign bus.reg_dst      = ctl_out.reg_dst;
    assign bus.mem_to_reg   = ctl_out.mem_to_reg;
    assign bus.reg_write_en = ctl_out.reg_write_en;
    assign bus.illegal_op   = ctl_out.illegal_op;
    assign bus.halted       = ctl_out.halted;
    assign bus.state_dbg    = state_q;
    assign bus.instr_count  = count_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_multicycle_sequencer
//
// For every instruction the bench writes down, from the instruction-level
// rules, the full list of cycles it must take and the control word expected in
// each one; that list is then played against the DUT cycle by cycle. A few
// literal values (cycle counts, counter values, halt/reset behaviour) pin the
// model. A narrow counter (CNT_W = 4) makes the wrap-around reachable.
// -----------------------------------------------------------------------------
module tb_multicycle_sequencer;

    localparam int CNT_W = 4;
`ifdef MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       imem_read;
        logic       mem_read_en;
        logic       mem_write_en;
        logic       alu_src;
        logic [2:0] alu_op;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write_en;
        logic       illegal_op;
        logic       halted;
        logic [2:0] state;
    } obs_t;

    typedef struct packed {
        obs_t exp;
        logic rdy;        // mem_ready driven this cycle
        logic halt;       // halt_req driven this cycle
        logic rstn;       // rst_n driven this cycle
        logic retire;     // instruction completes at the end of this cycle
        logic chk_state;  // compare state_dbg this cycle
    } item_t;

    logic clk;
    logic rst_n;

    multicycle_sequencer_if #(.CNT_W(CNT_W)) bus ();

    multicycle_sequencer #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int               n_checks = 0;
    int               n_pass   = 0;
    logic [CNT_W-1:0] model_cnt;
    item_t            q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", name, got, want, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.pc_write     = bus.pc_write;
        o.pc_src       = bus.pc_src;
        o.ir_write     = bus.ir_write;
        o.imem_read    = bus.imem_read;
        o.mem_read_en  = bus.mem_read_en;
        o.mem_write_en = bus.mem_write_en;
        o.alu_src      = bus.alu_src;
        o.alu_op       = bus.alu_op;
        o.reg_dst      = bus.reg_dst;
        o.mem_to_reg   = bus.mem_to_reg;
        o.reg_write_en = bus.reg_write_en;
        o.illegal_op   = bus.illegal_op;
        o.halted       = bus.halted;
        o.state        = bus.state_dbg;
        return o;
    endfunction

    function automatic item_t mk(input logic [2:0] st, input logic rdy, input logic halt);
        item_t it;
        it           = '0;
        it.exp.state = st;
        it.rdy       = rdy;
        it.halt      = halt;
        it.rstn      = 1'b1;
        it.chk_state = 1'b1;
        return it;
    endfunction

    // One clock cycle: drive inputs, compare at the falling edge, then
    // advance the model counter past the rising edge.
    task automatic step(input item_t it);
        obs_t got;
        rst_n         = it.rstn;
        bus.mem_ready = it.rdy;
        bus.halt_req  = it.halt;
        @(negedge clk);
        got = sample();
        if (!it.chk_state) got.state = it.exp.state;
        check($sformatf("ctl(state %0d)", it.exp.state), 32'(got), 32'(it.exp));
        check("instr_count", 32'(bus.instr_count), 32'(model_cnt));
        @(posedge clk);
        #1;
        if (!it.rstn) model_cnt = '0;
        else if (it.retire) model_cnt = model_cnt + 1'b1;
    endtask

    // Expected cycle list of one instruction. fw / mw are the requested wait
    // cycles in FETCH / MEM; without the wait option the bench still drives
    // mem_ready low on that single cycle to show it is ignored.
    task automatic build(input logic [3:0] op, input logic z, input int fw, input int mw, input bit hm);
        item_t      it;
        logic [3:0] amap;
        bit         lw, sw, alu, beq, bne, jmp, ill;
        int         nfw, nmw;
        lw   = (op == 4'd0);
        sw   = (op == 4'd1);
        alu  = (op >= 4'd2) && (op <= 4'd9);
        beq  = (op == 4'd11);
        bne  = (op == 4'd12);
        jmp  = (op == 4'd13);
        ill  = !(lw || sw || alu || beq || bne || jmp);
        amap = op - 4'd2;
        nfw  = WAIT_EN ? fw : 0;
        nmw  = WAIT_EN ? mw : 0;
        q.delete();

        for (int i = 0; i < nfw; i++) begin
            it = mk(3'd0, 1'b0, 1'b0);
            it.exp.imem_read = 1'b1;
            q.push_back(it);
        end
        it = mk(3'd0, (WAIT_EN || fw == 0), 1'b0);
        it.exp.imem_read = 1'b1;
        it.exp.ir_write  = 1'b1;
        it.exp.pc_write  = 1'b1;
        q.push_back(it);

        it = mk(3'd1, 1'b0, hm);
        if (jmp) begin
            it.exp.pc_write = 1'b1;
            it.exp.pc_src   = 2'b10;
            it.retire       = 1'b1;
        end
        if (ill) it.exp.illegal_op = 1'b1;
        q.push_back(it);
        if (jmp || ill) return;

        it = mk(3'd2, 1'b0, hm);
        if (lw || sw) begin
            it.exp.alu_src = 1'b1;
        end else if (alu) begin
            it.exp.reg_dst = 1'b1;
            it.exp.alu_op  = amap[2:0];
        end else begin
            it.exp.alu_op   = 3'b001;
            it.exp.pc_src   = 2'b01;
            it.exp.pc_write = beq ? z : !z;
            it.retire       = 1'b1;
        end
        q.push_back(it);
        if (beq || bne) return;

        if (lw || sw) begin
            for (int i = 0; i <= nmw; i++) begin
                it = mk(3'd3, (i == nmw) && (WAIT_EN || mw == 0), hm);
                it.exp.alu_src      = 1'b1;
                it.exp.mem_read_en  = lw;
                it.exp.mem_write_en = sw;
                it.retire           = sw && (i == nmw);
                q.push_back(it);
            end
            if (sw) return;
        end

        it = mk(3'd4, 1'b0, hm);
        it.exp.reg_write_en = 1'b1;
        it.retire           = 1'b1;
        if (lw) begin
            it.exp.mem_to_reg = 1'b1;
        end else begin
            it.exp.reg_dst = 1'b1;
            it.exp.alu_op  = amap[2:0];
        end
        q.push_back(it);
    endtask

    task automatic play();
        while (q.size() > 0) step(q.pop_front());
    endtask

    task automatic run_instr(input logic [3:0] op, input logic z, input int fw, input int mw,
                             input bit hm, input int want_cycles);
        bus.opcode = op;
        bus.zero   = z;
        build(op, z, fw, mw, hm);
        check($sformatf("cycles(op %b)", op), 32'(q.size()), 32'(want_cycles));
        play();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        item_t it;
        rst_n         = 1'b0;
        bus.opcode    = 4'd0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        bus.halt_req  = 1'b0;
        model_cnt     = '0;
        repeat (2) @(posedge clk);
        #1;
        // reset state: controls low, FETCH, counter cleared
        check("reset ctl+state", 32'(sample()), 32'd0);
        check("reset count", 32'(bus.instr_count), 32'd0);

        // LW, no waits: 5 cycles, count 1
        run_instr(4'b0000, 1'b0, 0, 0, 1'b0, 5);
        check("count after LW", 32'(bus.instr_count), 32'd1);

        // ADD then SLT: 8 cycles together
        run_instr(4'b0010, 1'b0, 0, 0, 1'b0, 4);
        run_instr(4'b1001, 1'b0, 0, 0, 1'b0, 4);
        check("count after ADD,SLT", 32'(bus.instr_count), 32'd3);

        // branches
        run_instr(4'b1011, 1'b1, 0, 0, 1'b0, 3);
        run_instr(4'b1011, 1'b0, 0, 0, 1'b0, 3);
        run_instr(4'b1100, 1'b0, 0, 0, 1'b0, 3);
        run_instr(4'b1100, 1'b1, 0, 0, 1'b0, 3);

        // SW with 3 MEM wait cycles, LW with FETCH and MEM waits
        run_instr(4'b0001, 1'b0, 0, 3, 1'b0, WAIT_EN ? 7 : 4);
        run_instr(4'b0000, 1'b0, 2, 1, 1'b0, WAIT_EN ? 8 : 5);

        // illegal opcodes leave the count alone; JMP retires in 2 cycles
        check("count before illegal", 32'(bus.instr_count), 32'd9);
        run_instr(4'b1110, 1'b0, 0, 0, 1'b0, 2);
        run_instr(4'b1010, 1'b0, 0, 0, 1'b0, 2);
        run_instr(4'b1111, 1'b0, 0, 0, 1'b0, 2);
        check("count after illegal", 32'(bus.instr_count), 32'd9);
        run_instr(4'b1101, 1'b0, 0, 0, 1'b0, 2);

        // every ALU opcode
        for (int op = 2; op <= 9; op++) run_instr(4'(op), 1'b0, 0, 0, 1'b0, 4);

        // halt raised mid-instruction, honoured only at the next FETCH
        run_instr(4'b0000, 1'b0, 0, 0, 1'b1, 5);
        for (int i = 0; i < 3; i++) begin
            it = mk(3'd0, 1'b1, 1'b1);
            it.exp.halted = 1'b1;
            step(it);
        end
        check("halted/imem_read", {30'd0, bus.halted, bus.imem_read}, 32'b10);
        run_instr(4'b0011, 1'b0, 0, 0, 1'b0, 4);

        // counter wrap from all-ones to zero
        while (model_cnt != '1) run_instr(4'b1101, 1'b0, 0, 0, 1'b0, 2);
        check("count all-ones", 32'(bus.instr_count), 32'hF);
        run_instr(4'b1101, 1'b0, 0, 0, 1'b0, 2);
        check("count wrapped", 32'(bus.instr_count), 32'd0);
        run_instr(4'b1101, 1'b0, 0, 0, 1'b0, 2);

        // reset asserted in MEM of LW: no WB, back in FETCH with count 0
        bus.opcode = 4'b0000;
        build(4'b0000, 1'b0, 0, 0, 1'b0);
        void'(q.pop_back());
        void'(q.pop_back());
        it           = '0;
        it.rdy       = 1'b1;
        it.exp.state = 3'd3;
        q.push_back(it);
        play();
        check("state after mid reset", 32'(bus.state_dbg), 32'd0);
        check("count after mid reset", 32'(bus.instr_count), 32'd0);
        run_instr(4'b0110, 1'b0, 0, 0, 1'b0, 4);
        check("count after resume", 32'(bus.instr_count), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
